multicycle_control: RTL and testbench



---
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multicycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback, and drives the datapath enables and mux selects from the
// current state.
// Optional feature macro: MULTICYCLE_CONTROL_ADDI_EN enables addi (opcode
// 001000) through ADDIEX/ADDIWB. When the macro is not defined, that opcode
// is illegal and codes 10/11 are handled as unused codes.
//
// state    | code | meaning
// FETCH    |  0   | read instruction, PC+4; stalls until memReady
// DECODE   |  1   | register read, branch target calc, opcode dispatch
// MEMADR   |  2   | lw/sw effective address
// MEMREAD  |  3   | lw data read; stalls until memReady
// MEMWB    |  4   | lw register writeback
// MEMWRITE |  5   | sw data write; stalls until memReady
// EXECUTE  |  6   | R-type ALU operation
// ALUWB    |  7   | R-type register writeback
// BRANCH   |  8   | beq compare and conditional PC update
// JUMP     |  9   | PC <- jump target
// ADDIEX   | 10   | addi ALU operation (feature build only)
// ADDIWB   | 11   | addi register writeback (feature build only)
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               irWrite,
  output logic               regWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               iorD,
  output logic               memToReg,
  output logic               regDst,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         pcSource,
  output logic               instrDone,
  output logic               illegalOp,
  output logic [STATE_W-1:0] estado
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDIEX   = 4'd10,
    ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q;
  state_t state_d;

  assign estado = state_q;

  // State register; reset is synchronous and wins over any pending stall.
  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic and per-state datapath controls.
  always_comb begin
    state_d     = FETCH;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    irWrite     = 1'b0;
    regWrite    = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    iorD        = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    instrDone   = 1'b0;
    illegalOp   = 1'b0;

    case (state_q)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
        state_d = memReady ? DECODE : FETCH;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = EXECUTE;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
          OP_ADDI:       state_d = ADDIEX;
`endif
          default: begin
            state_d   = FETCH;
            illegalOp = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        if (opcode == OP_LW)      state_d = MEMREAD;
        else if (opcode == OP_SW) state_d = MEMWRITE;
        else                      state_d = FETCH;
      end
      MEMREAD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        state_d = memReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      MEMWRITE: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = memReady;
        state_d   = memReady ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b01;
        state_d = ALUWB;
      end
      ALUWB: begin
        regDst    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b10;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        instrDone   = 1'b1;
      end
      JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        instrDone = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, irWrite, regWrite;
  logic       memRead, memWrite, iorD, memToReg, regDst, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic       instrDone, illegalOp;
  logic [3:0] estado;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .irWrite(irWrite),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .iorD(iorD), .memToReg(memToReg), .regDst(regDst), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .instrDone(instrDone), .illegalOp(illegalOp), .estado(estado)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; memReady = 1'b0; opcode = 6'b000000;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (estado !== 4'd0) begin n_err++; $display("FAIL reset_estado got=%0d exp=0", estado); end
    n_cmp++; if ({memRead, aluSrcB, irWrite, pcWrite, instrDone, illegalOp} !== 7'b1010000) begin
      n_err++; $display("FAIL reset_outs got=%b exp=1010000", {memRead, aluSrcB, irWrite, pcWrite, instrDone, illegalOp}); end
    n_cmp++; if ({regWrite, memWrite, aluOp, pcSource} !== 6'b0) begin
      n_err++; $display("FAIL reset_zero got=%b exp=000000", {regWrite, memWrite, aluOp, pcSource}); end
    memReady = 1'b1;
    #1;
    n_cmp++; if ({irWrite, pcWrite} !== 2'b11) begin n_err++; $display("FAIL fetch_ready got=%b exp=11", {irWrite, pcWrite}); end
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    int done_cnt = 0;
    opcode = 6'b000000; memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (estado !== exp_st[i][3:0]) begin n_err++; $display("FAIL rtype_seq[%0d] got=%0d exp=%0d", i, estado, exp_st[i]); end
      if (instrDone === 1'b1) done_cnt++;
      if (i == 2) begin
        n_cmp++; if ({aluOp, aluSrcA} !== 3'b011) begin n_err++; $display("FAIL rtype_exec got=%b exp=011", {aluOp, aluSrcA}); end
      end
      if (i == 3) begin
        n_cmp++; if ({regWrite, regDst, memToReg} !== 3'b110) begin n_err++; $display("FAIL rtype_wb got=%b exp=110", {regWrite, regDst, memToReg}); end
      end
      if (i < 4) tick();
    end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rtype_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_lw_stall();
    logic mr_vec [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   exp_st [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
    int   cycles = 0;
    opcode = 6'b100011;
    for (int i = 0; i < 10; i++) begin
      memReady = mr_vec[i];
      #1;
      cycles++;
      n_cmp++; if (estado !== exp_st[i][3:0]) begin n_err++; $display("FAIL lw_seq[%0d] got=%0d exp=%0d", i, estado, exp_st[i]); end
      if (i < 2) begin
        n_cmp++; if ({memRead, irWrite, pcWrite} !== 3'b100) begin n_err++; $display("FAIL lw_fetch_stall[%0d] got=%b exp=100", i, {memRead, irWrite, pcWrite}); end
      end
      if (i >= 5 && i <= 8) begin
        n_cmp++; if ({memRead, iorD, regWrite, instrDone} !== 4'b1100) begin n_err++; $display("FAIL lw_memread[%0d] got=%b exp=1100", i, {memRead, iorD, regWrite, instrDone}); end
      end
      if (i == 9) begin
        n_cmp++; if ({memToReg, regWrite, instrDone, regDst} !== 4'b1110) begin n_err++; $display("FAIL lw_memwb got=%b exp=1110", {memToReg, regWrite, instrDone, regDst}); end
      end
      tick();
    end
    #1;
    n_cmp++; if (estado !== 4'd0 || cycles !== 10) begin n_err++; $display("FAIL lw_total estado=%0d cycles=%0d exp estado=0 cycles=10", estado, cycles); end
  endtask

  task automatic test_beq_j();
    int exp_st[4] = '{0, 1, 8, 0};
    int exp_j [4] = '{0, 1, 9, 0};
    opcode = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      memReady = (i == 0) ? 1'b1 : 1'b0;
      #1;
      n_cmp++; if (estado !== exp_st[i][3:0]) begin n_err++; $display("FAIL beq_seq[%0d] got=%0d exp=%0d", i, estado, exp_st[i]); end
      if (i == 2) begin
        n_cmp++; if ({aluOp, pcWriteCond, pcSource, aluSrcA, instrDone, pcWrite} !== 8'b10101110) begin
          n_err++; $display("FAIL beq_outs got=%b exp=10101110", {aluOp, pcWriteCond, pcSource, aluSrcA, instrDone, pcWrite}); end
      end
      if (i < 3) tick();
    end
    opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      memReady = 1'b1;
      #1;
      n_cmp++; if (estado !== exp_j[i][3:0]) begin n_err++; $display("FAIL j_seq[%0d] got=%0d exp=%0d", i, estado, exp_j[i]); end
      if (i == 2) begin
        n_cmp++; if ({pcWrite, pcSource, pcWriteCond, instrDone} !== 5'b11001) begin
          n_err++; $display("FAIL j_outs got=%b exp=11001", {pcWrite, pcSource, pcWriteCond, instrDone}); end
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; memReady = 1'b1;
    #1;
    n_cmp++; if ({estado, illegalOp} !== 5'b00000) begin n_err++; $display("FAIL ill_fetch got=%b exp=00000", {estado, illegalOp}); end
    tick();
    n_cmp++; if ({estado, illegalOp} !== 5'b00011) begin n_err++; $display("FAIL ill_decode got=%b exp=00011", {estado, illegalOp}); end
    n_cmp++; if ({pcWrite, pcWriteCond, irWrite, regWrite, memWrite, instrDone} !== 6'b0) begin
      n_err++; $display("FAIL ill_writes got=%b exp=000000", {pcWrite, pcWriteCond, irWrite, regWrite, memWrite, instrDone}); end
    tick();
    n_cmp++; if ({estado, illegalOp} !== 5'b00000) begin n_err++; $display("FAIL ill_return got=%b exp=00000", {estado, illegalOp}); end
  endtask

  task automatic test_sw_and_reset();
    // Completing sw: instrDone only while memReady=1 in MEMWRITE.
    opcode = 6'b101011; memReady = 1'b1;
    tick(); tick(); tick();
    memReady = 1'b0;
    #1;
    n_cmp++; if ({estado, memWrite, iorD, instrDone} !== 7'b0101110) begin
      n_err++; $display("FAIL sw_stall got=%b exp=0101110", {estado, memWrite, iorD, instrDone}); end
    memReady = 1'b1;
    #1;
    n_cmp++; if (instrDone !== 1'b1) begin n_err++; $display("FAIL sw_done got=%b exp=1", instrDone); end
    tick();
    n_cmp++; if (estado !== 4'd0) begin n_err++; $display("FAIL sw_return got=%0d exp=0", estado); end
    // Second sw, reset while stalled in MEMWRITE.
    tick(); tick(); tick();
    memReady = 1'b0;
    tick();
    n_cmp++; if ({estado, memWrite} !== 5'b01011) begin n_err++; $display("FAIL sw_hold got=%b exp=01011", {estado, memWrite}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if ({estado, memWrite, memRead} !== 6'b000001) begin
      n_err++; $display("FAIL reset_memwrite got=%b exp=000001", {estado, memWrite, memRead}); end
  endtask

  task automatic test_addi();
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    int exp_st[5] = '{0, 1, 10, 11, 0};
    int n = 5;
`else
    int exp_st[5] = '{0, 1, 0, 0, 0};
    int n = 3;
`endif
    opcode = 6'b001000; memReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      n_cmp++; if (estado !== exp_st[i][3:0]) begin n_err++; $display("FAIL addi_seq[%0d] got=%0d exp=%0d", i, estado, exp_st[i]); end
      if (i == 1) begin
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        n_cmp++; if (illegalOp !== 1'b0) begin n_err++; $display("FAIL addi_illegal got=%b exp=0", illegalOp); end
`else
        n_cmp++; if (illegalOp !== 1'b1) begin n_err++; $display("FAIL addi_illegal got=%b exp=1", illegalOp); end
`endif
      end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      if (i == 2) begin
        n_cmp++; if ({aluSrcA, aluSrcB, aluOp} !== 5'b11000) begin n_err++; $display("FAIL addi_ex got=%b exp=11000", {aluSrcA, aluSrcB, aluOp}); end
      end
      if (i == 3) begin
        n_cmp++; if ({regWrite, regDst, memToReg, instrDone} !== 4'b1001) begin n_err++; $display("FAIL addi_wb got=%b exp=1001", {regWrite, regDst, memToReg, instrDone}); end
      end
`endif
      if (i < n - 1) tick();
    end
  endtask

  initial begin
    reset = 1'b0; opcode = 6'b0; memReady = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq_j();
    test_illegal();
    test_sw_and_reset();
    test_addi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
